// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: register map, CTRL field positions, mode codes and FSM states for timer_dev
package timer_dev_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;
  localparam int EN_BIT = 0;
  localparam int MODE_LSB = 1;
  localparam int MODE_MSB = 2;
  localparam int IM_BIT = 3;
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD = 2'd1;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CNT = 2'd2, S_INT = 2'd3} state_t;
  typedef struct packed {
    logic im;
    logic [1:0] mode;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/timer_dev_if.sv
// timer_dev_if: data-memory bus slice seen by the timer, plus its interrupt line
interface timer_dev_if;
  logic sel;
  logic we;
  logic [1:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic irq;
  modport master (output sel, we, addr, wdata, input rdata, irq);
  modport slave (input sel, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot and auto-reload modes
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  timer_dev_if.slave bus
);
  ctrl_t ctrl;
  state_t state, state_nxt;
  logic [CNT_W-1:0] preset, count;
  logic sticky, wr_ctrl, wr_preset, en_eff, int_oneshot;
  assign wr_ctrl = bus.sel & bus.we & (bus.addr == REG_CTRL);
  assign wr_preset = bus.sel & bus.we & (bus.addr == REG_PRESET);
  // FSM sees EN as it will be after this edge, so a CTRL write starts LOAD immediately
  assign en_eff = wr_ctrl ? bus.wdata[EN_BIT] : ctrl.en;
  assign int_oneshot = (state == S_INT) & (ctrl.mode != MODE_RELOAD);
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = en_eff ? S_LOAD : S_IDLE;
      S_LOAD: state_nxt = S_CNT;
      S_CNT: state_nxt = !en_eff ? S_IDLE : (count == '0 || count == CNT_W'(1)) ? S_INT : S_CNT;
      S_INT: state_nxt = int_oneshot ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD) count <= preset;
      else if (state == S_CNT && en_eff && count != '0) count <= count - CNT_W'(1);
    end
  end
  // bus writes take priority over the hardware EN clear and sticky set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
      preset <= '0;
      sticky <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_t'(bus.wdata[IM_BIT:EN_BIT]);
      else if (int_oneshot) ctrl.en <= 1'b0;
      if (wr_preset) preset <= bus.wdata[CNT_W-1:0];
      if (wr_ctrl | wr_preset) sticky <= 1'b0;
      else if (int_oneshot) sticky <= 1'b1;
    end
  end
  always_comb begin
    bus.rdata = (bus.addr == REG_CTRL) ? {28'b0, ctrl} :
                (bus.addr == REG_PRESET) ? 32'(preset) :
                (bus.addr == REG_COUNT) ? 32'(count) : 32'b0;
  end
  assign bus.irq = ctrl.im & ((state == S_INT) | sticky);
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed stimulus, timeline-based reference model and literal pins for timer_dev
module tb_timer_dev;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  timer_dev_if bus();
  timer_dev #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // model: a run is a timeline t edges after its start; LOAD at t=0, INT at t_int
  logic [3:0] m_ctrl;
  logic [31:0] m_preset, m_count;
  logic m_sticky, m_act;
  longint m_t, m_p, m_tint;

  function automatic logic m_in_int();
    return m_act && m_t >= 1 && m_t == m_tint;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_sticky = 0;
      m_act = 0; m_t = 0; m_p = 0; m_tint = 0;
    end else begin
      logic wc, wp, en, oneshot_int;
      wc = bus.sel && bus.we && bus.addr == 2'd0;
      wp = bus.sel && bus.we && bus.addr == 2'd1;
      en = wc ? bus.wdata[0] : m_ctrl[0];
      oneshot_int = m_in_int() && m_ctrl[2:1] != 2'd1;
      if (!m_act) begin
        if (en) begin m_act = 1; m_t = 0; end
      end else if (m_t == 0) begin
        m_p = longint'(m_preset);
        m_tint = (m_p == 0) ? 2 : m_p + 1;
        m_count = m_preset;
        m_t = 1;
      end else if (m_t == m_tint) begin
        if (oneshot_int) m_act = 0;
        else m_t = 0;
      end else if (!en) m_act = 0;
      else begin
        m_t = m_t + 1;
        m_count = 32'((m_p - (m_t - 1)) > 0 ? m_p - (m_t - 1) : 0);
      end
      if (wp) m_preset = bus.wdata;
      if (wc || wp) m_sticky = 0;
      else if (oneshot_int) m_sticky = 1;
      if (wc) m_ctrl = bus.wdata[3:0];
      else if (oneshot_int) m_ctrl[0] = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_rd;
    exp_rd = (bus.addr == 2'd0) ? {28'b0, m_ctrl} : (bus.addr == 2'd1) ? m_preset :
             (bus.addr == 2'd2) ? m_count : 32'b0;
    check("model rdata", bus.rdata, exp_rd);
    check("model irq", {31'b0, bus.irq}, {31'b0, m_ctrl[3] & (m_in_int() | m_sticky)});
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1; bus.we = 1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.sel = 0; bus.we = 0; bus.addr = 2'd2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pin(input logic [1:0] a, input string nm, input logic [31:0] exp);
    bus.addr = a; #1;
    check(nm, bus.rdata, exp);
    bus.addr = 2'd2;
  endtask

  task automatic pin_irq(input string nm, input logic exp);
    check(nm, {31'b0, bus.irq}, {31'b0, exp});
  endtask

  initial begin
    bus.sel = 0; bus.we = 0; bus.addr = 2'd2; bus.wdata = '0;
    idle(2);
    for (int a = 0; a < 4; a++) pin(2'(a), "reset rdata", 32'h0);
    pin_irq("reset irq", 0);
    reset = 1;
    idle(1);
    // reset mid-count
    wr(1, 10); wr(0, 9); idle(4);
    pin(2, "pre-reset count", 7);
    reset = 0; #1;
    for (int a = 0; a < 4; a++) pin(2'(a), "async reset rdata", 32'h0);
    pin_irq("async reset irq", 0);
    idle(2); reset = 1; idle(3);
    pin(2, "post-reset count frozen", 0);
    pin(0, "post-reset ctrl", 0);
    // mode 0 one-shot
    wr(1, 3); wr(0, 9);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      pin(2, "m0 count", 32'(4 - k));
      pin_irq("m0 irq", k == 4);
    end
    idle(1);
    pin(0, "m0 ctrl en cleared", 8);
    pin_irq("m0 irq sticky", 1);
    idle(2);
    pin_irq("m0 irq held", 1);
    wr(1, 5);
    pin_irq("m0 irq cleared by preset write", 0);
    // mode 1 auto-reload
    wr(1, 2); wr(0, 11);
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      pin_irq("m1 irq period", (k % 4) == 3);
    end
    pin(0, "m1 ctrl en kept", 11);
    wr(0, 10);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      pin_irq("m1 masked irq", 0);
    end
    wr(0, 0); idle(2);
    // pause / resume
    wr(1, 8); wr(0, 1); idle(3);
    pin(2, "pause before", 6);
    wr(0, 0);
    pin(2, "pause frozen", 6);
    idle(3);
    pin(2, "pause still frozen", 6);
    wr(0, 1); idle(1);
    pin(2, "resume reloads preset", 8);
    wr(0, 0);
    // PRESET = 0
    wr(1, 0); wr(0, 9); idle(1);
    pin(2, "p0 count after load", 0);
    pin_irq("p0 no irq in cnt", 0);
    idle(1);
    pin(2, "p0 count at int", 0);
    pin_irq("p0 irq at int", 1);
    idle(1);
    pin(2, "p0 no underflow", 0);
    wr(1, 4); wr(0, 1); idle(1);
    pin(2, "preset-in-cnt load", 4);
    wr(1, 9);
    idle(1);
    pin(2, "preset-in-cnt unchanged", 2);
    pin(1, "preset-in-cnt new preset", 9);
    idle(4);
    wr(0, 1); idle(1);
    pin(2, "new preset applies at load", 9);
    wr(0, 0);
    // ignored writes
    wr(2, 123);
    pin(2, "count write ignored", 9);
    wr(3, 5);
    pin(3, "reserved reads 0", 0);
    wr(0, 32'hFFFF_FFF0);
    pin(0, "ctrl upper bits ignored", 0);
    // collision: CTRL write in mode-0 INT cycle
    wr(1, 2); wr(0, 9); idle(3);
    pin_irq("coll int", 1);
    wr(0, 9);
    pin(0, "coll en kept", 9);
    pin_irq("coll sticky clear", 0);
    idle(1);
    pin_irq("coll load irq", 0);
    idle(1);
    pin(2, "coll reload", 2);
    wr(0, 0); idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer. Responds to the core's data-memory bus: the core initiates store/load requests and this block answers them.
- Sits behind the address decoder that also selects DM. The decoder drives sel for this block's 16-byte window.
- Provides three word registers (CTRL, PRESET, COUNT) and one interrupt line toward the core.
- Bus reads are combinational. Bus writes take effect on the clock edge.

Parameters:
- CNT_W, 32, width of PRESET and COUNT; reads are zero-extended to 32 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; reset==0 clears all state immediately
- sel  input  1  decoder hit for this block's window
- we  input  1  store strobe, qualified by sel
- addr  input  2  word index, byte address bits [3:2]
- wdata  input  32  store data
- rdata  output  32  load data, combinational on addr
- irq  output  1  interrupt request to core

Behaviour:
- Register map by word index:
  - 0 = CTRL (R/W): bit0 EN, bits2:1 MODE, bit3 IM; bits31:4 read 0, writes to them ignored.
  - 1 = PRESET (R/W).
  - 2 = COUNT (read-only; writes ignored).
  - 3 reads 0, writes ignored.
- Write occurs when sel & we at a rising edge. rdata reflects the current register selected by addr, independent of sel.
- Reset (reset==0): CTRL=0, PRESET=0, COUNT=0, state=IDLE, sticky=0. Consequently irq=0 and rdata=0 for every addr.
- FSM states IDLE, LOAD, CNT, INT, one transition per edge:
  - IDLE: EN=1 -> LOAD. COUNT holds.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT: EN=0 -> IDLE (COUNT holds). Else if COUNT==0 -> INT. Else COUNT<=COUNT-1; if COUNT==1 -> INT.
  - INT, MODE 0 (MODE 2/3 behave as 0): hardware clears EN, sets sticky; -> IDLE.
  - INT, MODE 1: -> LOAD (auto-reload). EN and sticky unchanged.
- irq = IM & ((state==INT) | sticky), registered state only, no bus-combinational path.
  - Mode 0: irq goes high on entry to INT and stays high until sticky is cleared.
  - Mode 1: irq is high for exactly the one INT cycle.
  - Mode 1 period, measured from one COUNT=PRESET load to the next, is PRESET+2 cycles.
- sticky is cleared by any bus write to CTRL or PRESET.
- Timing from a CTRL write with EN=1 at edge e0: LOAD after e0, COUNT=PRESET after e1, first decrement at e2.
- Simultaneous events:
  - A bus write to CTRL in the INT cycle wins over the hardware EN clear. In MODE 0, the sticky clear from the write also wins over the sticky set.
  - A PRESET write during CNT does not alter COUNT; the new value applies at the next LOAD.
  - A CTRL write with EN=0 in LOAD: the LOAD completes, then CNT sees EN=0 and goes to IDLE.
- PRESET=0: LOAD -> CNT -> INT with no decrement, so COUNT never underflows (no wrap-around ever).
- reset asserted mid-count aborts immediately to reset values. Operation resumes only after a new CTRL write.

Decomposition:
- Shared timer_defs header/package:
  - register word offsets 0..3;
  - CTRL bit positions EN=0, MODE=2:1, IM=3;
  - mode codes 0 and 1;
  - 2-bit state encodings IDLE/LOAD/CNT/INT.
- No sub-module. A single always block for the FSM/COUNT, a register-write block, and combinational read/irq logic.

Test Plan:
- Reset: hold reset=0 mid-operation, then release. All reads return 0, irq=0, and COUNT does not move with EN=0.
- Mode 0 one-shot: PRESET=3, CTRL=0x9 (EN, IM) at e0. COUNT reads 3,2,1,0 after e1..e4 and irq=1 from e4. After e5, CTRL reads 0x8 and irq stays 1. A write of PRESET=5 drops irq the next cycle.
- Mode 1 auto-reload: PRESET=2, CTRL=0xB. irq is high one cycle every 4 cycles for 3 periods. CTRL.EN stays 1; with CTRL=0xA instead, irq stays 0 while COUNT still cycles.
- Pause/resume: mid-count CTRL=0x0 -> COUNT freezes at its value within one cycle. Rewriting EN=1 reloads PRESET via LOAD and does not resume from the frozen value.
- PRESET=0 edge: CTRL=0x9 -> INT reached 2 edges after LOAD and COUNT stays 0 (no 0xFFFFFFFF). A PRESET write during CNT leaves the current countdown unchanged.
- Collision: a CTRL write of 0x9 in the mode-0 INT cycle -> EN remains 1, FSM goes IDLE->LOAD, and the sticky bit stays clear.
